// File: rtl/y_line_packer_if.sv
// Stream and Y SRAM write-port bundle for y_line_packer.
// The checksum member exists only when Y_PACK_CHECKSUM_EN is defined.
interface y_line_packer_if #(
  parameter int DATA_W = 16,
  parameter int WORDS  = 16,
  parameter int ADDR_W = 11
);
  logic                      start;
  logic [ADDR_W-1:0]         base_addr;
  logic [ADDR_W:0]           line_count;
  logic                      in_valid;
  logic [DATA_W-1:0]         in_data;
  logic                      in_ready;
  logic                      WE_Y;
  logic [ADDR_W-1:0]         yram_WriteAddress;
  logic [DATA_W*WORDS-1:0]   y_WriteBus;
  logic                      busy;
  logic                      done;
`ifdef Y_PACK_CHECKSUM_EN
  logic [DATA_W-1:0]         checksum;
`endif

  // Upstream feeder / controller side
  modport master (
    output start, base_addr, line_count, in_valid, in_data,
    input  in_ready, WE_Y, yram_WriteAddress, y_WriteBus, busy, done
`ifdef Y_PACK_CHECKSUM_EN
    , input checksum
`endif
  );

  // Packer side
  modport slave (
    input  start, base_addr, line_count, in_valid, in_data,
    output in_ready, WE_Y, yram_WriteAddress, y_WriteBus, busy, done
`ifdef Y_PACK_CHECKSUM_EN
    , output checksum
`endif
  );
endinterface

// File: rtl/y_line_packer.sv
// Packs 16-bit Y elements into 256-bit lines and writes them to consecutive Y SRAM addresses.
// Optional running element checksum is enabled by defining Y_PACK_CHECKSUM_EN.
module y_line_packer #(
  parameter int DATA_W = 16,
  parameter int WORDS  = 16,
  parameter int ADDR_W = 11
) (
  input  logic            clock,
  input  logic            reset_n,
  y_line_packer_if.slave  yIf
);
  localparam int LINE_W = DATA_W * WORDS;
  localparam int K_W    = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} stateT;

  stateT             stateReg, stateNext;
  logic [K_W-1:0]    kReg;
  logic [ADDR_W:0]   linesReg;
  logic [ADDR_W:0]   countReg;
  logic [ADDR_W:0]   linesInc;
  logic [ADDR_W-1:0] baseReg;
  logic [ADDR_W-1:0] addrReg;
  logic [LINE_W-1:0] lineReg;
  logic [LINE_W-1:0] lineNext;
  logic [LINE_W-1:0] busReg;
  logic              accept;
  logic              lastElem;
  logic              startAccept;

  assign accept      = (stateReg == FILL) && yIf.in_valid;
  assign lastElem    = accept && (kReg == K_W'(WORDS - 1));
  assign startAccept = (stateReg == IDLE) && yIf.start;
  assign linesInc    = linesReg + 1'b1;

  // Each lane only picks up the element whose index matches the fill counter.
  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_lane
      assign lineNext[gi*DATA_W +: DATA_W] =
        (accept && (kReg == K_W'(gi))) ? yIf.in_data : lineReg[gi*DATA_W +: DATA_W];
    end
  endgenerate

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (yIf.start) stateNext = (yIf.line_count == '0) ? DONE : FILL;
      FILL:    if (lastElem) stateNext = WRITE;
      WRITE:   stateNext = (linesInc == countReg) ? DONE : FILL;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stateReg <= IDLE;
      kReg     <= '0;
      linesReg <= '0;
      countReg <= '0;
      baseReg  <= '0;
      addrReg  <= '0;
      lineReg  <= '0;
      busReg   <= '0;
    end else begin
      stateReg <= stateNext;
      if (startAccept) begin
        baseReg  <= yIf.base_addr;
        countReg <= yIf.line_count;
        kReg     <= '0;
        linesReg <= '0;
      end
      if (accept) begin
        kReg    <= kReg + 1'b1;
        lineReg <= lineNext;
      end
      // Address and bus are loaded once per line so they hold between writes.
      if (lastElem) begin
        busReg  <= lineNext;
        addrReg <= baseReg + linesReg[ADDR_W-1:0];
      end
      if (stateReg == WRITE) begin
        linesReg <= linesInc;
        kReg     <= '0;
      end
    end
  end

`ifdef Y_PACK_CHECKSUM_EN
  logic [DATA_W-1:0] sumReg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sumReg <= '0;
    end else if (startAccept) begin
      sumReg <= '0;
    end else if (accept) begin
      sumReg <= sumReg + yIf.in_data;
    end
  end

  assign yIf.checksum = sumReg;
`endif

  assign yIf.in_ready          = (stateReg == FILL);
  assign yIf.WE_Y              = (stateReg == WRITE);
  assign yIf.busy              = (stateReg != IDLE);
  assign yIf.done              = (stateReg == DONE);
  assign yIf.yram_WriteAddress = addrReg;
  assign yIf.y_WriteBus        = busReg;
endmodule

// File: doc/y_line_packer.md
# y_line_packer

Upstream feeder for the Y SRAM in the Jacobi memory subsystem. Accepts a stream of 16-bit Y-vector elements over a valid/ready handshake. Packs each group of 16 elements into one 256-bit line. Writes each line into the Y SRAM write port (`WE_Y` / `yram_WriteAddress` / `y_WriteBus`) at consecutive addresses, starting from a programmed base, until a programmed number of lines is written.

## Interface
Parameters:
- `DATA_W`, 16: element width in bits.
- `WORDS`, 16: elements per line. Line width is `DATA_W*WORDS` = 256.
- `ADDR_W`, 11: Y SRAM address width.

Ports:
- `clock`, in, 1: the single clock; all state changes on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle request to begin a load. Sampled only in IDLE.
- `base_addr`, in, `ADDR_W`: first line address. Captured on the accepted `start`.
- `line_count`, in, `ADDR_W`+1: number of lines to write, 0..2048. Captured on the accepted `start`.
- `in_valid`, in, 1: `in_data` is valid.
- `in_data`, in, `DATA_W`: element.
- `in_ready`, out, 1: the block accepts an element this cycle.
- `WE_Y`, out, 1: Y SRAM write enable, one-cycle pulse per line.
- `yram_WriteAddress`, out, `ADDR_W`: Y SRAM write address.
- `y_WriteBus`, out, 256: packed line.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle pulse when the load completes.
- `checksum`, out, `DATA_W`: present only with `Y_PACK_CHECKSUM_EN`.

## Operation
- FSM states: IDLE, FILL, WRITE, DONE.
- IDLE:
  - `start`=1 captures `base_addr` and `line_count`, and clears the element and line counters.
  - If `line_count`=0, go to DONE. Otherwise go to FILL.
- FILL:
  - `in_ready`=1.
  - Each handshake (`in_valid` & `in_ready`) stores element k (k = 0..15) into bits [16k+15:16k] of the line register, then increments k.
  - The handshake that accepts element 15 moves the FSM to WRITE.
  - `in_valid`=0 stalls with no state change.
- WRITE:
  - `in_ready`=0.
  - `WE_Y`=1 with `yram_WriteAddress` = base + lines_written, taken modulo 2^`ADDR_W` (wraps 2047→0).
  - `y_WriteBus` = line register.
  - Increment lines_written and reset k to 0.
  - If lines_written (new) = line_count, go to DONE. Otherwise go to FILL.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `start` outside IDLE is ignored.
- Elements presented outside FILL are not consumed, because `in_ready`=0.
- Counters: k is 4 bits. lines_written is `ADDR_W`+1 bits. Address arithmetic is truncated to `ADDR_W`.

## Timing
- Reset values:
  - State IDLE.
  - `in_ready`, `WE_Y`, `busy`, `done` = 0.
  - `yram_WriteAddress` = 0, `y_WriteBus` = 0, `checksum` = 0.
  - Counters = 0.
- All outputs are registered or decoded from the registered state. No combinational path from `in_valid` to `in_ready`.
- Latency: the 16th handshake at edge N gives `WE_Y` high during cycle N+1. The next element can be accepted at edge N+2, so there is one bubble per line.
- Minimum load time for L lines with back-to-back input: 1 + 17L + 1 cycles, from the `start` edge to `done`.
- `yram_WriteAddress` and `y_WriteBus` hold their last written values while `WE_Y`=0.
- Reset asserted mid-load: immediate return to IDLE and all outputs at reset values. A partially filled line is discarded and no write is issued.

## Configuration
- `Y_PACK_CHECKSUM_EN` defined:
  - Adds the `checksum` output: a 16-bit modulo-2^16 sum of every element accepted since the last accepted `start`.
  - Cleared on an accepted `start`.
  - Final value is stable from the `done` cycle until the next `start`.
- Not defined: no `checksum` port or adder logic; all other behaviour is identical.

## Test plan
- Reset and idle:
  - Stimulus: assert `reset_n`=0 mid-FILL after 7 elements, release, start base=0x010, count=1, feed 16 elements.
  - Required: all outputs 0 during reset. Exactly one write, to 0x010, contains only the post-reset elements.
- Single line:
  - Stimulus: base=0x005, count=1, elements 0x0001..0x0010 back-to-back.
  - Required: one `WE_Y` pulse at address 0x005, `y_WriteBus`[15:0]=0x0001, [255:240]=0x0010. `done` 1 cycle after `WE_Y`.
- Wrap-around:
  - Stimulus: base=0x7FF, count=3.
  - Required: writes at 0x7FF, 0x000, 0x001. `done` after the third write.
- Backpressure:
  - Stimulus: `in_valid` toggling 1/0 every cycle, count=2.
  - Required: elements packed in handshake order. `in_ready`=0 exactly in each WRITE cycle. Total writes = 2.
- Zero count and ignored start:
  - Stimulus: count=0.
  - Required: `done` pulses 2 cycles after `start`, with no `WE_Y`.
  - Stimulus: `start` pulse during FILL.
  - Required: no change to address or count.
- Checksum, with `Y_PACK_CHECKSUM_EN` defined:
  - Stimulus: 32 elements of 0x1000.
  - Required: `checksum`=0x0000, since 0x20000 truncates to 16 bits. With elements 0x0001..0x0010, `checksum`=0x0088.
